mul_dsp_pipe: RTL



---
 rtl/mul_dsp_pipe.sv | 97 +++++++++
 1 files changed

// File: rtl/mul_dsp_pipe.sv
// Elastic pipelined multiply / multiply-accumulate unit for the PRNG datapath.
// A stall anywhere freezes every stage, so results are never dropped or reordered.
module mul_dsp_pipe #(
  parameter int unsigned W      = 16,
  parameter int unsigned STAGES = 3,
  parameter int unsigned G      = 8,
  parameter bit          SIGNED = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         a,
  input  logic [W-1:0]         b,
  input  logic                 in_acc,
  input  logic                 in_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*W+G-1:0]     p
);

  localparam int unsigned RW   = 2 * W + G;
  localparam int unsigned PW   = 2 * W;
  localparam int unsigned NMID = STAGES - 1;

  typedef struct packed {
    logic          vld;
    logic          acc;
    logic          clr;
    logic [RW-1:0] data;
  } slot_t;

  slot_t         pipe_q [NMID];
  slot_t         tail_c;
  logic [RW-1:0] prod_c;
  logic [RW-1:0] acc_q;
  logic [RW-1:0] acc_base_c;
  logic [RW-1:0] acc_sum_c;
  logic          en_c;

  // Product is formed at full 2W width, then widened to RW per operand signedness.
  if (SIGNED) begin : g_signed
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] prod_s;
    assign a_ext  = {{W{a[W-1]}}, a};
    assign b_ext  = {{W{b[W-1]}}, b};
    assign prod_s = a_ext * b_ext;
    assign prod_c = RW'(prod_s);
  end else begin : g_unsigned
    logic [PW-1:0] prod_u;
    assign prod_u = PW'(a) * PW'(b);
    assign prod_c = RW'(prod_u);
  end

  // Whole pipeline moves only when the output slot is empty or being consumed.
  assign en_c     = !out_valid || out_ready;
  assign in_ready = en_c;

  // Front and middle stages: plain shift register of slots, bubbles included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NMID; k++) begin
        pipe_q[k] <= '0;
      end
    end else if (en_c) begin
      pipe_q[0] <= '{vld: in_valid, acc: in_acc, clr: in_clr, data: prod_c};
      for (int unsigned k = 1; k < NMID; k++) begin
        pipe_q[k] <= pipe_q[k-1];
      end
    end
  end

  // Accumulation lives only in the last stage, so chained ops never hazard.
  assign tail_c     = pipe_q[NMID-1];
  assign acc_base_c = tail_c.clr ? '0 : acc_q;
  assign acc_sum_c  = acc_base_c + tail_c.data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      p         <= '0;
      acc_q     <= '0;
    end else if (en_c) begin
      out_valid <= tail_c.vld;
      if (tail_c.vld) begin
        if (tail_c.acc) begin
          p     <= acc_sum_c;
          acc_q <= acc_sum_c;
        end else begin
          p <= tail_c.data;
        end
      end
    end
  end

endmodule
